pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register: 1-cycle latency, in_ready is a flop (no out_ready->in_ready path), FULL backpressures.
// Define PIPE_STALL_CNT_EN to add the stall_cnt port counting cycles with out_valid high and out_ready low.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              push;
  logic              pop;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic              clr_main;
  logic              clr_skid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  // main_ctrl is kept zero whenever the stage is empty, so a bubble is a NOP
  assign out_ctrl = main_ctrl;
  assign out_data = main_data;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    clr_skid       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      clr_main  = 1'b1;
      clr_skid  = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
            clr_main  = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
            clr_skid       = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
          clr_main  = 1'b1;
          clr_skid  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clr_main) begin
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else if (clr_skid) begin
        skid_ctrl <= '0;
        skid_data <= '0;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Cleared only by reset; flush leaves the count intact
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based model compared every negedge plus directed literal checks.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } bundle_t;

  bundle_t     mq[$];
  int unsigned m_stall = 0;
  bit          m_push;
  bit          m_pop;
  bundle_t     m_nb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Model: the stage is an ordered queue of at most two bundles
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_stall = 0;
    end else begin
      m_push = in_valid && (mq.size() < 2);
      m_pop  = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          m_nb.c = in_ctrl;
          m_nb.d = in_data;
          mq.push_back(m_nb);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("m_out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
        check("m_out_data", 64'(out_data), 64'(mq[0].d));
      end else begin
        check("m_bubble_ctrl", 64'(out_ctrl), 64'(0));
      end
`ifdef PIPE_STALL_CNT_EN
      check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
`ifdef PIPE_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    RST = 1'b0;

    // Single bundle, one-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 4'b1001; in_data = 32'h0000_1234;
    tick();
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'(1));
    check("t1_ctrl", 64'(out_ctrl), 64'h9);
    check("t1_data", 64'(out_data), 64'h1234);
    tick();
    check("t1_empty_valid", 64'(out_valid), 64'(0));
    check("t1_empty_ctrl", 64'(out_ctrl), 64'(0));
    check("t1_empty_rdy", 64'(in_ready), 64'(1));

    // Fill under stall, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'h3; in_data = 32'hA;
    tick();
    in_ctrl = 4'h5; in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    check("t2_full_rdy", 64'(in_ready), 64'(0));
    check("t2_head", 64'(out_data), 64'hA);
    tick();
    check("t2_hold", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    tick();
    check("t2_second", 64'(out_data), 64'hB);
    check("t2_rdy_back", 64'(in_ready), 64'(1));
    tick();
    check("t2_drained", 64'(out_valid), 64'(0));

    // Backpressure in FULL, then flush with an offered bundle
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'h6; in_data = 32'hD;
    tick();
    in_ctrl = 4'h7; in_data = 32'hE;
    tick();
    in_ctrl = 4'hC; in_data = 32'hF;
    tick();
    tick();
    check("t3_bp_rdy", 64'(in_ready), 64'(0));
    check("t3_bp_head", 64'(out_data), 64'hD);
    check("t3_bp_ctrl", 64'(out_ctrl), 64'h6);
    flush = 1'b1;
    tick();
    check("t3_flush_valid", 64'(out_valid), 64'(0));
    check("t3_flush_ctrl", 64'(out_ctrl), 64'(0));
    check("t3_flush_rdy", 64'(in_ready), 64'(1));
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("t3_not_stored", 64'(out_valid), 64'(0));

    // Asynchronous reset between edges while ONE
    in_valid = 1'b1; in_ctrl = 4'hA; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    check("t4_one", 64'(out_valid), 64'(1));
    #2 RST = 1'b1;
    #1;
    check("t4_async_valid", 64'(out_valid), 64'(0));
    check("t4_async_ctrl", 64'(out_ctrl), 64'(0));
    check("t4_async_rdy", 64'(in_ready), 64'(1));
    #1 RST = 1'b0;

    // First push after reset, then five stall cycles and a flush
    in_valid = 1'b1; in_ctrl = 4'h2; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    check("t5_push_after_rst", 64'(out_valid), 64'(1));
    check("t5_data", 64'(out_data), 64'h55);
    repeat (5) tick();
`ifdef PIPE_STALL_CNT_EN
    check("t5_stall5", 64'(stall_cnt), 64'd5);
`endif
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flushed", 64'(out_valid), 64'(0));
`ifdef PIPE_STALL_CNT_EN
    check("t5_stall_kept", 64'(stall_cnt), 64'd5);
`endif

    // Streaming: one bundle per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_ctrl = 4'(i);
      in_data = 32'h1000 + 32'(i);
      tick();
      check("t6_data", 64'(out_data), 64'h1000 + 64'(i));
      check("t6_rdy", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    tick();
    check("t6_end", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
